// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: requester, shared-ALU and response signals of the ALU arbiter
interface alu_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 4
);
  logic              req0Valid;
  logic [DATA_W-1:0] req0A;
  logic [DATA_W-1:0] req0B;
  logic [OP_W-1:0]   req0Op;
  logic              req0Ready;
  logic              req1Valid;
  logic [DATA_W-1:0] req1A;
  logic [DATA_W-1:0] req1B;
  logic [OP_W-1:0]   req1Op;
  logic              req1Ready;
  logic [DATA_W-1:0] aluA;
  logic [DATA_W-1:0] aluB;
  logic [OP_W-1:0]   aluOp;
  logic [DATA_W-1:0] aluY;
  logic              respValid;
  logic              respId;
  logic [DATA_W-1:0] respY;
  logic              respErr;
  logic              respReady;

  modport master (
    output req0Valid, req0A, req0B, req0Op, req1Valid, req1A, req1B, req1Op, aluY, respReady,
    input  req0Ready, req1Ready, aluA, aluB, aluOp, respValid, respId, respY, respErr
  );

  modport slave (
    input  req0Valid, req0A, req0B, req0Op, req1Valid, req1A, req1B, req1Op, aluY, respReady,
    output req0Ready, req1Ready, aluA, aluB, aluOp, respValid, respId, respY, respErr
  );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one ALU between two requesters with a one-entry result register
module alu_arbiter #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 4
) (
  input logic         clk,
  input logic         rst,
  alu_arbiter_if.slave bus
);
  logic              prio_q;
  logic              resp_valid_q;
  logic              resp_id_q;
  logic              resp_err_q;
  logic [DATA_W-1:0] resp_y_q;
  logic              can_accept;
  logic              win1;
  logic              grant;
  logic              sup;
  logic [OP_W-1:0]   op;

  // Pick the winner, grant it when the result register has room, and steer it onto the ALU
  always_comb begin
    can_accept    = !resp_valid_q || bus.respReady;
    win1          = bus.req1Valid && (!bus.req0Valid || prio_q);
    grant         = !rst && can_accept && (bus.req0Valid || bus.req1Valid);
    bus.req0Ready = grant && !win1;
    bus.req1Ready = grant && win1;
    op            = win1 ? bus.req1Op : bus.req0Op;
    sup           = op == OP_W'(0) || op == OP_W'(2) || (op >= OP_W'(4) && op <= OP_W'(10));
    bus.aluA      = grant ? (win1 ? bus.req1A : bus.req0A) : '0;
    bus.aluB      = grant ? (win1 ? bus.req1B : bus.req0B) : '0;
    bus.aluOp     = grant ? op : '0;
  end

  // Capture the granted result (or an error for unsupported codes) and hand priority to the loser
  always_ff @(posedge clk) begin
    if (rst) begin
      prio_q       <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_y_q     <= '0;
    end else if (grant) begin
      prio_q       <= !win1;
      resp_valid_q <= 1'b1;
      resp_id_q    <= win1;
      resp_err_q   <= !sup;
      resp_y_q     <= sup ? bus.aluY : '0;
    end else if (bus.respReady) begin
      resp_valid_q <= 1'b0;
    end
  end

  assign bus.respValid = resp_valid_q;
  assign bus.respId    = resp_id_q;
  assign bus.respY     = resp_y_q;
  assign bus.respErr   = resp_err_q;
endmodule
